// File: rtl/div_if.sv
// div_if: EX-stage handshake between the pipeline and the divide sequencer
interface div_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [1:0]      op_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            flush_i;
  logic            stall_o;
  logic            busy_o;
  logic            valid_o;
  logic [XLEN-1:0] result_o;
  modport master (
    output start_i, op_i, a_i, b_i, flush_i,
    input  stall_o, busy_o, valid_o, result_o
  );
  modport slave (
    input  start_i, op_i, a_i, b_i, flush_i,
    output stall_o, busy_o, valid_o, result_o
  );
endinterface

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
module div_sequencer #(
  parameter int XLEN = 32
) (
  input logic  clk,
  input logic  rst_n,
  div_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [1:0]      op_q, op_d;
  logic            sa_q, sa_d, sb_q, sb_d, fast_q, fast_d;
  logic            sgn, go, ge, fix;
  logic [XLEN-1:0] a_abs, b_abs, rem_sh, sel;
  always_comb begin
    sgn     = ~bus.op_i[0];
    go      = (state_q == IDLE) & bus.start_i & ~bus.flush_i;
    a_abs   = (sgn & bus.a_i[XLEN-1]) ? -bus.a_i : bus.a_i;
    b_abs   = (sgn & bus.b_i[XLEN-1]) ? -bus.b_i : bus.b_i;
    rem_sh  = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
    ge      = rem_sh >= dvs_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    fast_d  = fast_q;
    case (state_q)
      IDLE: if (go) begin
        op_d   = bus.op_i;
        sa_d   = sgn & bus.a_i[XLEN-1];
        sb_d   = sgn & bus.b_i[XLEN-1];
        dvs_d  = b_abs;
        cnt_d  = CW'(XLEN - 1);
        fast_d = 1'b1;
        if (bus.b_i == '0) begin
          state_d = DONE;
          quo_d   = '1;
          rem_d   = bus.a_i;
        end else if (sgn & (bus.a_i == MIN) & (bus.b_i == '1)) begin
          state_d = DONE;
          quo_d   = MIN;
          rem_d   = '0;
        end else begin
          state_d = CALC;
          quo_d   = a_abs;
          rem_d   = '0;
          fast_d  = 1'b0;
        end
      end
      CALC: begin
        rem_d   = ge ? rem_sh - dvs_q : rem_sh;
        quo_d   = {quo_q[XLEN-2:0], ge};
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == '0) ? DONE : CALC;
      end
      default: state_d = IDLE;
    endcase
    if (bus.flush_i) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      fast_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      fast_q  <= fast_d;
    end
  end
  always_comb begin
    fix          = ~fast_q & ~op_q[0] & (op_q[1] ? sa_q : sa_q ^ sb_q);
    sel          = op_q[1] ? rem_q : quo_q;
    bus.stall_o  = go | (state_q == CALC);
    bus.busy_o   = state_q != IDLE;
    bus.valid_o  = state_q == DONE;
    bus.result_o = bus.valid_o ? (fix ? -sel : sel) : '0;
  end
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed and randomized checks of div_sequencer against an arithmetic model
module tb_div_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;
  div_if #(.XLEN(32)) bus ();
  div_sequencer #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t dir[$] = '{
    '{2'b01, 32'd100, 32'd7, 32'd14},
    '{2'b11, 32'd100, 32'd7, 32'd2},
    '{2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD},
    '{2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF},
    '{2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1},
    '{2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF},
    '{2'b11, 32'd5, 32'd0, 32'd5},
    '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
    '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0}
  };
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
      return op[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    end
    return op[1] ? a % b : a / b;
  endfunction
  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
  endfunction
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.a_i     = a;
    bus.b_i     = b;
  endtask
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int lat = ref_lat(op, a, b);
    int first = 0;
    int n = 0;
    int bad = 0;
    logic [31:0] res = '0;
    launch(op, a, b);
    @(negedge clk);
    chk("stall_start", 32'(bus.stall_o), 32'd1);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      bus.start_i = 1'b0;
      bus.op_i    = 2'($urandom);
      bus.a_i     = $urandom;
      bus.b_i     = $urandom;
      @(negedge clk);
      if (bus.valid_o) begin
        n++;
        if (first == 0) begin
          first = k;
          res = bus.result_o;
        end
      end else if (bus.result_o != 0) bad++;
      if (bus.stall_o != (k < lat)) bad++;
      if (bus.busy_o != (k <= lat)) bad++;
    end
    chk("latency", 32'(first), 32'(lat));
    chk("nvalid", 32'(n), 32'd1);
    chk("result", res, exp);
    chk("stall_busy_seq", 32'(bad), 32'd0);
  endtask
  initial begin
    int nv;
    int vk[$];
    logic [31:0] ra, rb;
    logic [1:0]  rop;
    bus.start_i = 1'b0;
    bus.op_i    = '0;
    bus.a_i     = '0;
    bus.b_i     = '0;
    bus.flush_i = 1'b0;
    #2;
    chk("reset_flags", {29'd0, bus.stall_o, bus.busy_o, bus.valid_o}, 32'd0);
    chk("reset_result", bus.result_o, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    foreach (dir[i]) run_op(dir[i].op, dir[i].a, dir[i].b, dir[i].exp);
    launch(2'b01, 32'd100, 32'd7);
    nv = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      bus.start_i = 1'b0;
      bus.flush_i = (k == 10);
      @(negedge clk);
      if (bus.valid_o) nv++;
      if (k == 11) chk("flush_busy", 32'(bus.busy_o), 32'd0);
    end
    chk("flush_nvalid", 32'(nv), 32'd0);
    run_op(2'b01, 32'd9, 32'd3, 32'd3);
    @(posedge clk);
    #1;
    bus.start_i = 1'b1;
    bus.flush_i = 1'b1;
    @(negedge clk);
    chk("flush_start_stall", 32'(bus.stall_o), 32'd0);
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    @(negedge clk);
    chk("flush_start_busy", 32'(bus.busy_o), 32'd0);
    launch(2'b01, 32'd100, 32'd7);
    for (int k = 1; k <= 34; k++) begin
      @(posedge clk);
      #1;
      bus.start_i = 1'b0;
      bus.flush_i = (k == 33);
      @(negedge clk);
      if (k == 33) begin
        chk("flush_done_valid", 32'(bus.valid_o), 32'd1);
        chk("flush_done_result", bus.result_o, 32'd14);
      end
      if (k == 34) chk("flush_done_after", {30'd0, bus.busy_o, bus.valid_o}, 32'd0);
    end
    launch(2'b01, 32'd100, 32'd7);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      bus.start_i = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("rst_mid_flags", {29'd0, bus.stall_o, bus.busy_o, bus.valid_o}, 32'd0);
    chk("rst_mid_result", bus.result_o, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    nv = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.valid_o || bus.busy_o) nv++;
    end
    chk("rst_no_residual", 32'(nv), 32'd0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
    launch(2'b01, 32'd100, 32'd7);
    nv = 0;
    for (int k = 1; k <= 101; k++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      if (bus.valid_o) begin
        vk.push_back(k);
        if (bus.result_o != 32'd14) nv++;
      end
    end
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    chk("b2b_count", 32'(vk.size()), 32'd3);
    chk("b2b_results", 32'(nv), 32'd0);
    if (vk.size() == 3) begin
      chk("b2b_first", 32'(vk[0]), 32'd33);
      chk("b2b_gap1", 32'(vk[1] - vk[0]), 32'd34);
      chk("b2b_gap2", 32'(vk[2] - vk[1]), 32'd34);
    end
    @(negedge clk);
    chk("b2b_idle", 32'(bus.busy_o), 32'd0);
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom);
      case ($urandom_range(0, 3))
        0: ra = $urandom_range(0, 100);
        1: ra = 32'h8000_0000;
        2: ra = -32'($urandom_range(1, 100));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = $urandom_range(1, 20);
        3: rb = -32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, ref_res(rop, ra, rb));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
